// File: rtl/lfsr_checker.sv
// lfsr_checker: self-seeding XNOR-LFSR PRBS receiver with lock detection and error counting
module lfsr_checker #(
    parameter int WIDTH      = 10,
    parameter int X1         = 6,
    parameter int X2         = 9,
    parameter int LOCK_CNT   = 16,
    parameter int WIN        = 64,
    parameter int ERR_THRESH = 4,
    parameter int ERRW       = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            din,
    input  logic            din_valid,
    input  logic            clear_cnt,
    output logic            locked,
    output logic            err,
    output logic [ERRW-1:0] err_count,
    output logic            lockup,
    output logic [1:0]      state
);
    localparam int SW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WIN);
    localparam int EW = $clog2(ERR_THRESH + 1);
    typedef enum logic [1:0] {SEED = 2'b00, VERIFY = 2'b01, LOCKED = 2'b10} st_t;
    st_t st, st_n;
    logic [WIDTH-1:0] r, r_n;
    logic [SW-1:0] seed_cnt, seed_n;
    logic [GW-1:0] good_cnt, good_n;
    logic [WW-1:0] win_cnt, win_n;
    logic [EW-1:0] win_err, werr_n;
    logic [ERRW-1:0] ecnt_n;
    logic lockup_n, pred, miss, wend;
    assign pred   = r[X1] ~^ r[X2];
    assign wend   = win_cnt == WW'(WIN - 1);
    assign locked = st == LOCKED;
    assign state  = st;
    always_comb begin
        st_n     = st;
        r_n      = r;
        seed_n   = seed_cnt;
        good_n   = good_cnt;
        win_n    = win_cnt;
        werr_n   = win_err;
        lockup_n = lockup;
        miss     = 1'b0;
        if (din_valid) begin
            case (st)
                VERIFY: begin
                    r_n = {r[WIDTH-2:0], din};
                    if (din == pred) begin
                        good_n = good_cnt + 1'b1;
                        if (good_cnt == GW'(LOCK_CNT - 1)) begin
                            st_n   = LOCKED;
                            win_n  = '0;
                            werr_n = '0;
                        end
                    end else begin
                        st_n   = SEED;
                        seed_n = SW'(1);
                    end
                end
                LOCKED: begin
                    // flywheel: the prediction, not the line bit, feeds the register
                    r_n    = {r[WIDTH-2:0], pred};
                    miss   = din != pred;
                    win_n  = wend ? '0 : win_cnt + 1'b1;
                    werr_n = (wend ? '0 : win_err) + EW'(miss);
                    if (werr_n == EW'(ERR_THRESH)) begin
                        st_n   = SEED;
                        seed_n = '0;
                    end
                end
                default: begin
                    r_n = {r[WIDTH-2:0], din};
                    if (seed_cnt == SW'(WIDTH - 1)) begin
                        seed_n   = '0;
                        lockup_n = &r_n;
                        st_n     = &r_n ? SEED : VERIFY;
                        good_n   = '0;
                    end else begin
                        seed_n = seed_cnt + 1'b1;
                    end
                end
            endcase
        end
        ecnt_n = clear_cnt ? '0 : (miss && !(&err_count)) ? err_count + 1'b1 : err_count;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= SEED;
            r         <= '0;
            seed_cnt  <= '0;
            good_cnt  <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err       <= 1'b0;
            err_count <= '0;
            lockup    <= 1'b0;
        end else begin
            st        <= st_n;
            r         <= r_n;
            seed_cnt  <= seed_n;
            good_cnt  <= good_n;
            win_cnt   <= win_n;
            win_err   <= werr_n;
            err       <= miss;
            err_count <= ecnt_n;
            lockup    <= lockup_n;
        end
    end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: table vectors, directed corner cases and random traffic against a queue-based model
module tb_lfsr_checker;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic clear_cnt = 1'b0;
    logic locked, err, lockup;
    logic [15:0] err_count;
    logic [1:0] state;
    int vectors = 0;
    int miscompares = 0;

    lfsr_checker dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
        .locked(locked), .err(err), .err_count(err_count), .lockup(lockup), .state(state)
    );

    always #5 clk = ~clk;

    bit tx[$];
    bit hist[$];
    int m_st, m_seed, m_good, m_win, m_werr, m_ecnt;
    bit m_lockup, m_err;

    function automatic void model_reset();
        hist = {};
        tx = {};
        for (int i = 0; i < 10; i++) begin
            hist.push_back(1'b0);
            tx.push_back(1'b0);
        end
        m_st = 0; m_seed = 0; m_good = 0; m_win = 0; m_werr = 0; m_ecnt = 0;
        m_lockup = 0; m_err = 0;
    endfunction

    // PRBS source: s[n] = s[n-7] xnor s[n-10], history seeded with zeros
    function automatic bit gen();
        bit g;
        g = ~(tx[tx.size()-7] ^ tx[tx.size()-10]);
        tx.push_back(g);
        void'(tx.pop_front());
        return g;
    endfunction

    function automatic void model_step(bit d, bit v, bit c);
        bit p, miss, ones;
        miss = 0;
        m_err = 0;
        if (v) begin
            p = ~(hist[hist.size()-7] ^ hist[hist.size()-10]);
            hist.push_back(m_st == 2 ? p : d);
            void'(hist.pop_front());
            if (m_st == 0) begin
                m_seed++;
                if (m_seed == 10) begin
                    ones = 1;
                    foreach (hist[i]) ones &= hist[i];
                    m_seed = 0;
                    m_lockup = ones;
                    if (!ones) begin m_st = 1; m_good = 0; end
                end
            end else if (m_st == 1) begin
                if (d == p) begin
                    m_good++;
                    if (m_good == 16) begin m_st = 2; m_win = 0; m_werr = 0; end
                end else begin
                    m_st = 0; m_seed = 1;
                end
            end else begin
                miss = d != p;
                m_win++;
                if (m_win == 64) begin m_win = 0; m_werr = 0; end
                if (miss) m_werr++;
                m_err = miss;
                if (m_werr == 4) begin m_st = 0; m_seed = 0; end
            end
        end
        if (c) m_ecnt = 0;
        else if (miss && m_ecnt < 65535) m_ecnt++;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick(input bit d, input bit v, input bit c);
        din = d; din_valid = v; clear_cnt = c;
        @(posedge clk);
        model_step(d, v, c);
        #1;
        chk("cycle {locked,err,lockup,state,err_count}", {locked, err, lockup, state, err_count},
            {m_st == 2, m_err, m_lockup, 2'(m_st), 16'(m_ecnt)});
    endtask

    task automatic send(input bit flip, input bit v, input bit c);
        bit b;
        b = v ? gen() ^ flip : 1'($urandom);
        tick(b, v, c);
    endtask

    task automatic do_reset();
        reset = 1'b1; din_valid = 1'b0; clear_cnt = 1'b0;
        #1;
        model_reset();
        chk("async reset outputs", {locked, err, lockup, state, err_count}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {bit d; bit v; bit c; logic [1:0] st; bit lk; bit lcd;} vec_t;
    vec_t tbl[21];

    initial begin
        int pulses, seen, rate;
        for (int i = 0; i < 9; i++) tbl[i] = '{1, 1, 0, 2'd0, 0, 0};
        tbl[9]  = '{1, 1, 0, 2'd0, 1, 0};
        tbl[10] = '{1, 0, 0, 2'd0, 1, 0};
        tbl[11] = '{0, 1, 0, 2'd0, 1, 0};
        for (int i = 12; i < 20; i++) tbl[i] = '{1, 1, 0, 2'd0, 1, 0};
        tbl[20] = '{1, 1, 0, 2'd1, 0, 0};

        do_reset();
        foreach (tbl[i]) begin
            tick(tbl[i].d, tbl[i].v, tbl[i].c);
            chk("table {state,lockup,locked}", {state, lockup, locked}, {tbl[i].st, tbl[i].lk, tbl[i].lcd});
        end

        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            seen |= locked;
        end
        chk("const-1 lockup", lockup, 1);
        chk("const-1 never locked", seen, 0);

        do_reset();
        for (int i = 1; i <= 1023; i++) begin
            send(0, 1, 0);
            if (i == 25) chk("lock not before 26", locked, 0);
            if (i == 26) chk("lock at 26", locked, 1);
        end
        chk("clean err_count", err_count, 0);

        pulses = 0;
        for (int i = 1; i <= 300; i++) begin
            send(i == 200, 1, 0);
            pulses += err;
        end
        chk("single flip pulses", pulses, 1);
        chk("single flip count", err_count, 1);
        chk("single flip locked", locked, 1);

        send(1, 1, 1);
        chk("clear vs inc err", err, 1);
        chk("clear vs inc count", err_count, 0);

        // align to a fresh 64-bit window (1298 locked bits so far)
        for (int i = 0; i < 46; i++) send(0, 1, 0);
        for (int i = 0; i <= 30; i++) begin
            send(i % 10 == 0, 1, 0);
            if (i == 29) chk("3 errors keep lock", locked, 1);
        end
        chk("4th error drops lock", locked, 0);
        chk("4th error pulse", err, 1);
        chk("4 errors count", err_count, 4);
        for (int i = 1; i <= 26; i++) begin
            send(0, 1, 0);
            if (i == 25) chk("relock not before 26", locked, 0);
        end
        chk("relock at 26", locked, 1);

        for (int i = 0; i < 4; i++) send(1, 1, 0);
        for (int i = 0; i < 15; i++) send(0, 1, 0);
        chk("in VERIFY", state, 2'd1);
        chk("count before reset", err_count, 8);
        do_reset();

        for (int k = 1; k <= 52; k++) begin
            send(0, k % 2, 0);
            if (k == 50) chk("alt valid not locked", locked, 0);
            if (k == 51) chk("alt valid locked", locked, 1);
        end
        chk("alt valid still locked", locked, 1);

        do_reset();
        for (int s = 0; s < 16; s++) begin
            rate = (s % 4 == 0) ? 1000 : (s % 4 == 1) ? 40 : (s % 4 == 2) ? 8 : 2;
            for (int i = 0; i < 250; i++)
                send($urandom_range(0, rate) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
